// File: rtl/softmax_head_arbiter_if.sv
// rtl/softmax_head_arbiter_if.sv - head-side and engine-side bus of the softmax head arbiter
interface softmax_head_arbiter_if #(
    parameter int H     = 4,
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int MW = N * N * WIDTH;

    logic [H-1:0]    req;
    logic [H*MW-1:0] head_in;
    logic [H-1:0]    gnt;
    logic [H-1:0]    head_done;
    logic [MW-1:0]   head_out;
    logic            sm_start;
    logic [MW-1:0]   sm_in;
    logic            sm_done;
    logic [MW-1:0]   sm_out;

    modport master (
        output req, head_in, sm_done, sm_out,
        input  gnt, head_done, head_out, sm_start, sm_in
    );

    modport slave (
        input  req, head_in, sm_done, sm_out,
        output gnt, head_done, head_out, sm_start, sm_in
    );
endinterface

// File: rtl/softmax_head_arbiter.sv
// rtl/softmax_head_arbiter.sv - round-robin sharing of one mat_softmax engine among H heads
// Optional WAIT timeout with sticky err output: define SOFTMAX_TIMEOUT_EN.
module softmax_head_arbiter #(
    parameter int H     = 4,
    parameter int N     = 4,
    parameter int WIDTH = 32
`ifdef SOFTMAX_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    softmax_head_arbiter_if.slave  bus,
    output logic                   busy
`ifdef SOFTMAX_TIMEOUT_EN
    ,
    output logic                   err
`endif
);
    localparam int MW = N * N * WIDTH;
    localparam int IW = $clog2(H);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr, idx, pick, cand;
    logic            pick_vld;
    logic [MW-1:0]   snap;
    logic            done_q;
    logic            done_rise;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= H) s = s - H;
        return IW'(s);
    endfunction

    // Only a fresh rising edge counts, so a done level left over from the last run is ignored.
    assign done_rise = bus.sm_done & ~done_q;

`ifdef SOFTMAX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          to_hit;
    assign to_hit = (cnt == CW'(TIMEOUT)) && !done_rise;
`endif

    // Scan downwards so the candidate closest to rr_ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = H - 1; k >= 0; k--) begin
            cand = wrap(rr_ptr, k);
            if (bus.req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        snap = '0;
        for (int h = 0; h < H; h++) begin
            if (pick == IW'(h)) snap = bus.head_in[h*MW +: MW];
        end
    end

    always_comb begin
        state_nx      = state;
        bus.sm_start  = 1'b0;
        bus.head_done = '0;
        case (state)
            IDLE:  if (pick_vld) state_nx = START;
            START: begin
                bus.sm_start = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (done_rise) state_nx = RESP;
`ifdef SOFTMAX_TIMEOUT_EN
                else if (to_hit) state_nx = RESP;
`endif
            end
            RESP: begin
                bus.head_done = bus.gnt;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            idx          <= '0;
            done_q       <= 1'b0;
            bus.gnt      <= '0;
            bus.head_out <= '0;
            bus.sm_in    <= '0;
`ifdef SOFTMAX_TIMEOUT_EN
            cnt          <= '0;
            err          <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            done_q <= bus.sm_done;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        idx       <= pick;
                        bus.gnt   <= H'(1) << pick;
                        bus.sm_in <= snap;
`ifdef SOFTMAX_TIMEOUT_EN
                        err       <= 1'b0;
`endif
                    end
                end
                START: begin
`ifdef SOFTMAX_TIMEOUT_EN
                    cnt <= '0;
`endif
                end
                WAIT: begin
                    if (done_rise) bus.head_out <= bus.sm_out;
`ifdef SOFTMAX_TIMEOUT_EN
                    else if (to_hit) begin
                        bus.head_out <= '0;
                        err          <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    bus.gnt <= '0;
                    rr_ptr  <= wrap(idx, 1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_head_arbiter.sv
// tb/tb_softmax_head_arbiter.sv - scoreboard bench for softmax_head_arbiter with an engine stub
`timescale 1ns/1ps
module tb_softmax_head_arbiter;
    localparam int H     = 4;
    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int MW    = N * N * WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef SOFTMAX_TIMEOUT_EN
    logic err;
`endif

    always #5 clk = ~clk;

    softmax_head_arbiter_if #(.H(H), .N(N), .WIDTH(WIDTH)) bus ();

    softmax_head_arbiter #(
        .H(H), .N(N), .WIDTH(WIDTH)
`ifdef SOFTMAX_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
`ifdef SOFTMAX_TIMEOUT_EN
        , .err(err)
`endif
    );

    typedef struct {
        logic [H-1:0]  hd;
        logic [MW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   epoch = 0;
    int   hold_cyc = 3;
    bit   never_done = 1'b0;

    function automatic logic [MW-1:0] plus1(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*WIDTH +: WIDTH] = m[e*WIDTH +: WIDTH] + 1'b1;
        return r;
    endfunction

    function automatic logic [MW-1:0] slice(input int h);
        return bus.head_in[h*MW +: MW];
    endfunction

    task automatic rand_heads();
        for (int e = 0; e < H * N * N; e++)
            bus.head_in[e*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 32'h0000_FFFF));
    endtask

    task automatic push_exp(input int h);
        exp_t e;
        e.hd    = '0;
        e.hd[h] = 1'b1;
        e.data  = plus1(slice(h));
        sb.push_back(e);
    endtask

    task automatic wait_dones(input int k, input int budget, output int seen);
        int c;
        seen = 0;
        c = 0;
        while (seen < k && c < budget) begin
            @(negedge clk);
            c++;
            if (bus.head_done != '0) seen++;
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        int c;
        ok = 1'b0;
        c = 0;
        while (!ok && c < budget) begin
            @(negedge clk);
            c++;
            if (bus.sm_start) ok = 1'b1;
        end
    endtask

    // Counts cycles after the current one until head_done, 0 if it never comes.
    task automatic cycles_to_done(input int budget, output int n, output int extra_starts);
        n = 0;
        extra_starts = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (bus.sm_start) extra_starts++;
            if (bus.head_done != '0) begin
                n = c;
                break;
            end
        end
    endtask

    // Engine stub: done rises 10 edges after the start edge, held hold_cyc cycles; dies on reset.
    task automatic serve(input int ep);
        repeat (10) @(posedge clk);
        if (ep != epoch) return;
        #1;
        bus.sm_out  = plus1(bus.sm_in);
        bus.sm_done = 1'b1;
        repeat (hold_cyc) @(posedge clk);
        if (ep != epoch) return;
        #1;
        bus.sm_done = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst_n && bus.sm_start && !never_done) begin
            fork
                serve(epoch);
            join_none
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus.gnt != '0) begin
            tests++;
            if (!$onehot(bus.gnt)) begin
                fails++;
                $display("FAIL gnt_onehot: gnt=%b, required exactly one bit", bus.gnt);
            end
        end
        if (rst_n && bus.head_done != '0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: head_done=%b, required no pulse", bus.head_done);
            end else begin
                mon_e = sb.pop_front();
                if (bus.head_done !== mon_e.hd || bus.head_out !== mon_e.data) begin
                    fails++;
                    $display("FAIL sb_result: head_done=%b head_out=%h, required %b %h",
                             bus.head_done, bus.head_out, mon_e.hd, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests++; if (bus.gnt !== '0)       begin fails++; $display("FAIL rst_gnt: %b, required 0", bus.gnt); end
        tests++; if (bus.head_done !== '0) begin fails++; $display("FAIL rst_head_done: %b, required 0", bus.head_done); end
        tests++; if (bus.head_out !== '0)  begin fails++; $display("FAIL rst_head_out: %h, required 0", bus.head_out); end
        tests++; if (bus.sm_start !== 1'b0) begin fails++; $display("FAIL rst_sm_start: %b, required 0", bus.sm_start); end
        tests++; if (bus.sm_in !== '0)     begin fails++; $display("FAIL rst_sm_in: %h, required 0", bus.sm_in); end
        tests++; if (busy !== 1'b0)        begin fails++; $display("FAIL rst_busy: %b, required 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [4*WIDTH-1:0] row_exp;
        int n, xs;
        rand_heads();
        bus.head_in[0*WIDTH +: WIDTH] = 32'h40;
        bus.head_in[1*WIDTH +: WIDTH] = 32'h20;
        bus.head_in[2*WIDTH +: WIDTH] = 32'h10;
        bus.head_in[3*WIDTH +: WIDTH] = 32'h30;
        row_exp = {32'h31, 32'h11, 32'h21, 32'h41};
        bus.req = 4'b0001;
        push_exp(0);
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0001)  begin fails++; $display("FAIL single_gnt: %b, required 0001", bus.gnt); end
        tests++; if (bus.sm_start !== 1'b1) begin fails++; $display("FAIL single_start: %b, required 1", bus.sm_start); end
        tests++; if (bus.sm_in !== slice(0)) begin fails++; $display("FAIL single_sm_in: %h, required %h", bus.sm_in, slice(0)); end
        tests++; if (busy !== 1'b1)        begin fails++; $display("FAIL single_busy: %b, required 1", busy); end
        bus.req = '0;
        cycles_to_done(40, n, xs);
        tests++; if (n !== 12) begin fails++; $display("FAIL single_latency: %0d cycles, required 12", n); end
        tests++; if (xs !== 0) begin fails++; $display("FAIL single_start_pulse: %0d extra start cycles, required 0", xs); end
        tests++; if (bus.head_out[4*WIDTH-1:0] !== row_exp) begin
            fails++; $display("FAIL single_row0: %h, required %h", bus.head_out[4*WIDTH-1:0], row_exp);
        end
        @(negedge clk);
        tests++; if (bus.gnt !== '0 || busy !== 1'b0 || bus.head_done !== '0) begin
            fails++; $display("FAIL single_idle: gnt=%b busy=%b done=%b, required 0 0 0", bus.gnt, busy, bus.head_done);
        end
    endtask

    task automatic test_contention();
        int seen;
        rand_heads();
        bus.req = 4'b1010;
        push_exp(1);
        push_exp(3);
        wait_dones(2, 100, seen);
        bus.req = '0;
        tests++; if (seen !== 2) begin fails++; $display("FAIL contention_dones: %0d, required 2", seen); end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int seen;
        rand_heads();
        bus.req = 4'b1111;
        for (int s = 0; s < 8; s++) push_exp(s % H);
        wait_dones(8, 300, seen);
        bus.req = '0;
        tests++; if (seen !== 8) begin fails++; $display("FAIL fairness_dones: %0d, required 8", seen); end
        @(negedge clk);
    endtask

    task automatic test_stale_drop();
        int seen, n, xs, c;
        bit ok;
        hold_cyc = 8;
        rand_heads();
        bus.req = 4'b0100;
        push_exp(2);
        c = 0;
        while (bus.gnt !== 4'b0100 && c < 20) begin
            @(negedge clk);
            c++;
        end
        tests++; if (bus.gnt !== 4'b0100) begin fails++; $display("FAIL stale_gnt2: %b, required 0100", bus.gnt); end
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'b0001;
        push_exp(0);
        wait_dones(1, 40, seen);
        tests++; if (seen !== 1) begin fails++; $display("FAIL stale_drop_done: %0d, required 1", seen); end
        wait_start(10, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL stale_restart: no start, required one"); end
        bus.req = '0;
        cycles_to_done(60, n, xs);
        tests++; if (n !== 12) begin fails++; $display("FAIL stale_fresh_edge: %0d cycles, required 12", n); end
        hold_cyc = 3;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        bit ok;
        rand_heads();
        bus.req = 4'b0010;
        push_exp(1);
        wait_dones(1, 60, seen);
        bus.req = '0;
        tests++; if (seen !== 1) begin fails++; $display("FAIL rmid_pre_done: %0d, required 1", seen); end
        @(negedge clk);
        bus.req = 4'b0100;
        wait_start(10, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rmid_start: no start, required one"); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        epoch++;
        bus.sm_done = 1'b0;
        bus.req = '0;
        #1;
        tests++; if (bus.gnt !== '0 || busy !== 1'b0 || bus.head_done !== '0) begin
            fails++; $display("FAIL rmid_clear: gnt=%b busy=%b done=%b, required 0 0 0", bus.gnt, busy, bus.head_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.req = 4'b0110;
        push_exp(1);
        @(negedge clk);
        tests++; if (bus.gnt !== 4'b0010) begin fails++; $display("FAIL rmid_rr_ptr: gnt=%b, required 0010", bus.gnt); end
        bus.req = '0;
        wait_dones(1, 60, seen);
        tests++; if (seen !== 1) begin fails++; $display("FAIL rmid_post_done: %0d, required 1", seen); end
        repeat (4) @(negedge clk);
    endtask

`ifdef SOFTMAX_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int n, xs, seen;
        bit ok;
        never_done = 1'b1;
        rand_heads();
        bus.req = 4'b0001;
        e.hd = 4'b0001;
        e.data = '0;
        sb.push_back(e);
        wait_start(10, ok);
        bus.req = '0;
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL to_start: no start, required one"); end
        @(negedge clk);
        cycles_to_done(40, n, xs);
        tests++; if (n !== 17) begin fails++; $display("FAIL to_latency: %0d cycles, required 17", n); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err_set: %b, required 1", err); end
        @(negedge clk);
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err_sticky: %b, required 1", err); end
        never_done = 1'b0;
        bus.req = 4'b0010;
        push_exp(1);
        @(negedge clk);
        bus.req = '0;
        tests++; if (bus.gnt !== 4'b0010 || err !== 1'b0) begin
            fails++; $display("FAIL to_err_clear: gnt=%b err=%b, required 0010 0", bus.gnt, err);
        end
        wait_dones(1, 60, seen);
        tests++; if (seen !== 1) begin fails++; $display("FAIL to_after_done: %0d, required 1", seen); end
    endtask
`endif

    initial begin
        bus.req     = '0;
        bus.head_in = '0;
        bus.sm_done = 1'b0;
        bus.sm_out  = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_stale_drop();
        test_reset_mid();
`ifdef SOFTMAX_TIMEOUT_EN
        test_timeout();
`endif
        repeat (4) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/softmax_head_arbiter.md
Name: softmax_head_arbiter

Overview:
- Shares one mat_softmax engine (N x N, row-wise softmax) between H attention-head requesters.
- Round-robin arbitration. Each granted head's input matrix is snapshotted into the engine input register.
- Sequences the engine's start/done handshake and returns the result matrix with a one-cycle done pulse to the granted head.
- Sits between the per-head score (QK^T) stage and the score*V stage.

Parameters:
- H, 4, number of head requesters (2..16).
- N, 4, matrix dimension, matches mat_softmax N.
- WIDTH, 32, element width in bits, matches mat_softmax WIDTH.
- TIMEOUT, 1024, max cycles in WAIT; only used with SOFTMAX_TIMEOUT_EN.

Ports:
- clk, input, 1, clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, H, per-head level request; bit h = head h.
- head_in, input, H*N*N*WIDTH, head h matrix at slice h; element [i][j] at offset (i*N+j)*WIDTH.
- gnt, output, H, one-hot grant, high from capture until the head_done cycle.
- head_done, output, H, one-cycle pulse on the granted head's bit; head_out valid that cycle.
- head_out, output, N*N*WIDTH, registered result matrix, held until the next capture.
- busy, output, 1, high in any state other than IDLE.
- sm_start, output, 1, one-cycle start pulse to the engine.
- sm_in, output, N*N*WIDTH, registered snapshot of the granted head_in slice.
- sm_done, input, 1, engine done (level).
- sm_out, input, N*N*WIDTH, engine result.
- err, output, 1, timeout flag; present only with SOFTMAX_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, head_done=0, head_out=0, sm_start=0, sm_in=0, busy=0.
  - rr_ptr=0, done_q=0, state=IDLE.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If req!=0, pick the first set bit searching rr_ptr, rr_ptr+1, ... mod H.
  - Register idx; set gnt[idx]=1; copy head_in slice idx into sm_in; go START.
  - If req==0, stay in IDLE.
- START: sm_start=1 for exactly this one cycle; go WAIT.
- WAIT:
  - done_q registers sm_done every cycle.
  - Accept only a rising edge (sm_done=1 and done_q=0). A level left high from a previous run is ignored.
  - On the edge: head_out<=sm_out; go RESP.
- RESP:
  - head_done[idx]=1 for one cycle; gnt cleared at the end of the cycle.
  - rr_ptr<=(idx+1) mod H; go IDLE.
- Latency:
  - req sampled at edge k gives gnt/sm_in valid and sm_start high for cycle k+1.
  - An sm_done rise sampled at edge m gives head_done high for cycle m+1.
  - Minimum back-to-back gap between services: one IDLE cycle.
- Request rules:
  - req deassertion while granted is ignored; the service completes and head_done still pulses.
  - A head whose req stays high after head_done is re-served only after all other pending heads (fairness bound: H services).
  - Requests arriving during service are held by level; there is no queueing beyond that.
- sm_in is stable from START until the next IDLE capture. head_in may change freely after the grant.
- Width rule: pure data routing, no arithmetic on matrix data. The slice index is computed with $clog2(H) bits.
- Reset mid-operation: immediate return to reset values and any in-flight result is discarded. The engine must share rst_n.

Optional Feature:
- Macro: SOFTMAX_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT+1) bits clears on entry to WAIT and increments each WAIT cycle.
  - At count==TIMEOUT with no done edge: head_out<=0, err<=1, go RESP (head_done still pulses).
  - err is sticky until the next IDLE capture.
- Undefined: no counter; WAIT waits indefinitely; err port absent.

Test Plan:
- Bench engine stub: asserts sm_done 10 cycles after sm_start and holds it 3 cycles; sm_out = sm_in elementwise + 1.
- Single request: req=4'b0001, head_in[0] row0={0x40,0x20,0x10,0x30}. Expect:
  - gnt=0001 next cycle with a one-cycle sm_start.
  - head_done=0001 12 cycles after sm_start, head_out row0={0x41,0x21,0x11,0x31}.
- Contention: req=4'b1010 held to head_done. Expect:
  - Head 1 served first, then head 3.
  - Exactly one gnt bit high at any time; each head_done pulses once.
- Fairness: req=4'b1111 held continuously for 8 services. Expect grant order 0,1,2,3,0,1,2,3, each result matching its own head_in+1.
- Stale done/drop: stub holds sm_done high into the next IDLE; head 2 drops req 2 cycles after gnt. Expect:
  - The next service waits for a fresh rising edge.
  - Head 2 still receives a head_done pulse.
- Reset mid-WAIT: rst_n=0 five cycles after sm_start. Expect:
  - gnt, busy, head_done all 0 immediately.
  - rr_ptr=0, so the first request after release (req=4'b0110) grants head 1.
- Timeout (SOFTMAX_TIMEOUT_EN, TIMEOUT=16): stub never asserts done. Expect:
  - head_done pulse 17 cycles after WAIT entry, with head_out=0 and err=1.
  - err cleared at the next grant.
